reset_req_button_seq: RTL and testbench



---
 rtl/reset_req_pkg.sv | 44 ++++
 rtl/ms_tick_gen.sv | 38 +++
 rtl/reset_req_button_seq.sv | 163 ++++++++++++++++
 tb/tb_reset_req_button_seq.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/reset_req_pkg.sv
// +--------------------------------------------------------------------------+
// | Module      : reset_req_pkg                                              |
// | Description : Shared state encoding, request bit indices and armed codes |
// |               for the key-press to HPS reset-request sequencer.          |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
`default_nettype none

package reset_req_pkg;

    typedef logic [2:0] state_t;

    localparam state_t c_ST_IDLE       = 3'd0;
    localparam state_t c_ST_HOLD_DBG   = 3'd1;
    localparam state_t c_ST_HOLD_CHORD = 3'd2;
    localparam state_t c_ST_ISSUE      = 3'd3;
    localparam state_t c_ST_WAIT_REL   = 3'd4;

    localparam int REQ_COLD  = 0;
    localparam int REQ_WARM  = 1;
    localparam int REQ_DEBUG = 2;

    localparam logic [1:0] ARMED_NONE  = 2'd0;
    localparam logic [1:0] ARMED_WARM  = 2'd1;
    localparam logic [1:0] ARMED_COLD  = 2'd2;
    localparam logic [1:0] ARMED_DEBUG = 2'd3;

    // Classification a release would produce, given which thresholds are met.
    function automatic logic [1:0] armed_code(input logic is_chord, input logic cold_met,
                                              input logic warm_met, input logic dbg_met);
        logic [1:0] code;
        code = ARMED_NONE;
        if (is_chord) begin
            if (cold_met)      code = ARMED_COLD;
            else if (warm_met) code = ARMED_WARM;
        end else if (dbg_met) begin
            code = ARMED_DEBUG;
        end
        return code;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ms_tick_gen.sv
// +--------------------------------------------------------------------------+
// | Module      : ms_tick_gen                                                |
// | Description : Prescaler counting 0..TICK_DIV-1 with synchronous clear;   |
// |               one-cycle tick on the wrap cycle.                          |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
`default_nettype none

module ms_tick_gen #(
    parameter int TICK_DIV = 50000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_clr,
    output logic o_tick
);

    localparam int c_CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [c_CW-1:0] c_LAST = c_CW'(TICK_DIV - 1);

    logic [c_CW-1:0] r_cnt;

    // A clear cycle never ticks, so the first tick lands TICK_DIV cycles after it.
    assign o_tick = (r_cnt == c_LAST) && !i_clr;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (i_clr || o_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/reset_req_button_seq.sv
// +--------------------------------------------------------------------------+
// | Module      : reset_req_button_seq                                       |
// | Description : Turns long presses on two debounced keys into one-hot      |
// |               cold/warm/debug HPS reset requests. Optional macro         |
// |               RESET_REQ_ARMED_LED_EN adds the 'armed' LED output.        |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
`default_nettype none

module reset_req_button_seq
    import reset_req_pkg::*;
#(
    parameter int TICK_DIV   = 50000,
    parameter int CHORD_MS   = 200,
    parameter int WARM_MS    = 2000,
    parameter int COLD_MS    = 5000,
    parameter int DEBUG_MS   = 3000,
    parameter int REQ_CYCLES = 16,
    parameter int MS_W       = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] key_n,
    output logic [2:0] reset_req,
`ifdef RESET_REQ_ARMED_LED_EN
    output logic [1:0] armed,
`endif
    output logic       busy
);

    localparam int c_IW = (REQ_CYCLES > 1) ? $clog2(REQ_CYCLES) : 1;
    localparam logic [c_IW-1:0] c_ISSUE_LAST = c_IW'(REQ_CYCLES - 1);
    localparam logic [MS_W-1:0] c_CHORD = MS_W'(CHORD_MS);
    localparam logic [MS_W-1:0] c_WARM  = MS_W'(WARM_MS);
    localparam logic [MS_W-1:0] c_COLD  = MS_W'(COLD_MS);
    localparam logic [MS_W-1:0] c_DEBUG = MS_W'(DEBUG_MS);

    state_t          r_state;
    state_t          w_next;
    logic [MS_W-1:0] r_ms_cnt;
    logic [MS_W-1:0] w_ms_inc;
    logic [c_IW-1:0] r_issue_cnt;
    logic [2:0]      r_req_vec;
    logic [2:0]      w_req_vec;
    logic            w_hold_entry;
    logic            w_next_hold;
    logic            w_clr;
    logic            w_tick;

    always_comb begin
        w_next       = r_state;
        w_req_vec    = r_req_vec;
        w_hold_entry = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (key_n == 2'b00) begin
                    w_next       = c_ST_HOLD_CHORD;
                    w_hold_entry = 1'b1;
                end else if (key_n == 2'b01) begin
                    w_next       = c_ST_HOLD_DBG;
                    w_hold_entry = 1'b1;
                end
            end
            c_ST_HOLD_DBG: begin
                if (key_n == 2'b00) begin
                    if (r_ms_cnt < c_CHORD) begin
                        w_next       = c_ST_HOLD_CHORD;
                        w_hold_entry = 1'b1;
                    end else begin
                        w_next = c_ST_WAIT_REL;
                    end
                end else if (key_n[1]) begin
                    if (r_ms_cnt >= c_DEBUG) begin
                        w_next               = c_ST_ISSUE;
                        w_req_vec            = '0;
                        w_req_vec[REQ_DEBUG] = 1'b1;
                    end else begin
                        w_next = c_ST_WAIT_REL;
                    end
                end
            end
            c_ST_HOLD_CHORD: begin
                if (key_n != 2'b00) begin
                    if (r_ms_cnt >= c_COLD) begin
                        w_next              = c_ST_ISSUE;
                        w_req_vec           = '0;
                        w_req_vec[REQ_COLD] = 1'b1;
                    end else if (r_ms_cnt >= c_WARM) begin
                        w_next              = c_ST_ISSUE;
                        w_req_vec           = '0;
                        w_req_vec[REQ_WARM] = 1'b1;
                    end else begin
                        w_next = c_ST_WAIT_REL;
                    end
                end
            end
            c_ST_ISSUE: begin
                if (r_issue_cnt == c_ISSUE_LAST) w_next = c_ST_WAIT_REL;
            end
            c_ST_WAIT_REL: begin
                if (key_n == 2'b11) w_next = c_ST_IDLE;
            end
            default: w_next = c_ST_IDLE;
        endcase
    end

    // Time base is held cleared outside the hold states and restarted on each entry.
    assign w_next_hold = (w_next == c_ST_HOLD_DBG) || (w_next == c_ST_HOLD_CHORD);
    assign w_clr       = w_hold_entry || !w_next_hold;
    assign w_ms_inc    = (&r_ms_cnt) ? r_ms_cnt : r_ms_cnt + 1'b1;

    ms_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_ms_tick_gen (
        .clk     (clk),
        .reset_n (reset_n),
        .i_clr   (w_clr),
        .o_tick  (w_tick)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= c_ST_IDLE;
            r_req_vec   <= '0;
            r_ms_cnt    <= '0;
            r_issue_cnt <= '0;
        end else begin
            r_state   <= w_next;
            r_req_vec <= w_req_vec;
            if (w_clr)       r_ms_cnt <= '0;
            else if (w_tick) r_ms_cnt <= w_ms_inc;
            if (r_state == c_ST_ISSUE) r_issue_cnt <= r_issue_cnt + 1'b1;
            else                       r_issue_cnt <= '0;
        end
    end

    assign reset_req = (r_state == c_ST_ISSUE) ? r_req_vec : 3'b000;
    assign busy      = (r_state != c_ST_IDLE);

`ifdef RESET_REQ_ARMED_LED_EN
    logic [1:0] r_armed;
    logic [1:0] w_armed_nxt;

    // Classified from the value ms_cnt takes on this tick, so it tracks ms_cnt exactly.
    assign w_armed_nxt = armed_code(r_state == c_ST_HOLD_CHORD, w_ms_inc >= c_COLD,
                                    w_ms_inc >= c_WARM, w_ms_inc >= c_DEBUG);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_armed <= ARMED_NONE;
        end else if (w_clr) begin
            r_armed <= ARMED_NONE;
        end else if (w_tick) begin
            r_armed <= w_armed_nxt;
        end
    end

    assign armed = r_armed;
`endif

endmodule

`default_nettype wire

// File: tb/tb_reset_req_button_seq.sv
// +--------------------------------------------------------------------------+
// | Module      : tb_reset_req_button_seq                                    |
// | Description : Scoreboard bench for reset_req_button_seq (short timebase).|
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_reset_req_button_seq;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [1:0] key_n;
    logic [2:0] reset_req;
    logic       busy;
`ifdef RESET_REQ_ARMED_LED_EN
    logic [1:0] armed;
`endif

    typedef struct {
        logic [2:0] req;
        int         rel;
    } exp_t;

    exp_t       exp_q[$];
    int         cyc = 0;
    int         n_cmp = 0;
    int         n_err = 0;

    logic       in_pulse = 1'b0;
    logic [2:0] p_val;
    int         p_len;
    int         p_start;
    exp_t       p_exp;

    reset_req_button_seq #(
        .TICK_DIV   (10),
        .CHORD_MS   (2),
        .WARM_MS    (20),
        .COLD_MS    (50),
        .DEBUG_MS   (30),
        .REQ_CYCLES (4),
        .MS_W       (16)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .key_n     (key_n),
        .reset_req (reset_req),
`ifdef RESET_REQ_ARMED_LED_EN
        .armed     (armed),
`endif
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Each request pulse is measured as a whole, then checked against the queue head.
    always @(negedge clk) begin
        if (!reset_n) begin
            in_pulse = 1'b0;
        end else if (reset_req != 3'b000) begin
            if (!in_pulse) begin
                in_pulse = 1'b1;
                p_val    = reset_req;
                p_len    = 1;
                p_start  = cyc;
            end else begin
                p_val = p_val | reset_req;
                p_len++;
            end
        end else if (in_pulse) begin
            in_pulse = 1'b0;
            if (exp_q.size() == 0) begin
                chk("unexpected_req", 32'(p_val), 0);
            end else begin
                p_exp = exp_q.pop_front();
                chk("req_val", 32'(p_val), 32'(p_exp.req));
                chk("req_len", p_len, 4);
                chk("req_lat", p_start - p_exp.rel, 1);
            end
        end
    end

    task automatic run_seq(input logic [1:0] ka, input int ha, input logic [1:0] kb,
                           input int hb, input logic [1:0] krel, input logic [2:0] exp_req);
        exp_t x;
        key_n = ka;
        step(ha);
        chk("busy_press", busy, (ka == 2'b10) ? 0 : 1);
        if (hb > 0) begin
            key_n = kb;
            step(hb);
        end
        key_n = krel;
        if (exp_req != 3'b000) begin
            x.req = exp_req;
            x.rel = cyc;
            exp_q.push_back(x);
        end
        step(10);
        chk("busy_rel", busy, (krel == 2'b11) ? 0 : 1);
        key_n = 2'b11;
        step(3);
        chk("busy_idle", busy, 0);
        chk("pending", exp_q.size(), 0);
    endtask

    initial begin
        exp_t x;
        reset_n = 1'b0;
        key_n   = 2'b11;
        step(3);
        chk("rst_req", 32'(reset_req), 0);
        chk("rst_busy", busy, 0);
`ifdef RESET_REQ_ARMED_LED_EN
        chk("rst_armed", 32'(armed), 0);
`endif
        reset_n = 1'b1;
        step(2);

        run_seq(2'b00, 255,  2'b00, 0,   2'b01, 3'b010);  // chord 25 ms -> warm
        run_seq(2'b00, 605,  2'b00, 0,   2'b01, 3'b001);  // chord 60 ms -> cold
        run_seq(2'b00, 155,  2'b00, 0,   2'b01, 3'b000);  // chord 15 ms -> none
        run_seq(2'b00, 201,  2'b00, 0,   2'b11, 3'b010);  // warm exactly at 20 ms
        run_seq(2'b00, 200,  2'b00, 0,   2'b11, 3'b000);  // one cycle short of 20 ms
        run_seq(2'b01, 355,  2'b01, 0,   2'b11, 3'b100);  // KEY1 35 ms -> debug
        run_seq(2'b01, 295,  2'b01, 0,   2'b11, 3'b000);  // KEY1 29 ms -> none
        run_seq(2'b01, 301,  2'b01, 0,   2'b11, 3'b100);  // debug exactly at 30 ms
        run_seq(2'b01, 300,  2'b01, 0,   2'b11, 3'b000);
        run_seq(2'b01, 15,   2'b00, 255, 2'b01, 3'b010);  // late chord within window
        run_seq(2'b01, 55,   2'b00, 100, 2'b01, 3'b000);  // chord window missed
        run_seq(2'b10, 1000, 2'b10, 0,   2'b11, 3'b000);  // KEY0 alone ignored

        // Async reset on the second ISSUE cycle must kill the pulse outright.
        key_n = 2'b00;
        step(255);
        key_n = 2'b11;
        step(2);
        chk("req_pre_rst", 32'(reset_req), 32'(3'b010));
        #1 reset_n = 1'b0;
        #1;
        chk("req_async_rst", 32'(reset_req), 0);
        chk("busy_async_rst", busy, 0);
        step(3);
        reset_n = 1'b1;
        step(20);
        chk("busy_post_rst", busy, 0);
        chk("pending_post_rst", exp_q.size(), 0);

`ifdef RESET_REQ_ARMED_LED_EN
        key_n = 2'b00;
        step(200);
        chk("armed_ms19", 32'(armed), 0);
        step(1);
        chk("armed_ms20", 32'(armed), 1);
        step(299);
        chk("armed_ms49", 32'(armed), 1);
        step(1);
        chk("armed_ms50", 32'(armed), 2);
        key_n = 2'b11;
        x.req = 3'b001;
        x.rel = cyc;
        exp_q.push_back(x);
        step(12);
        chk("armed_idle", 32'(armed), 0);
        key_n = 2'b01;
        step(300);
        chk("armed_dbg29", 32'(armed), 0);
        step(1);
        chk("armed_dbg30", 32'(armed), 3);
        key_n = 2'b11;
        x.req = 3'b100;
        x.rel = cyc;
        exp_q.push_back(x);
        step(12);
        chk("armed_pending", exp_q.size(), 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
